// File: rtl/game_ctrl.sv
// Frame-synchronous game sequencer: decides when the playfield runs, pauses,
// respawns, advances a level or ends, and owns the lives/level/BCD score registers.
module game_ctrl #(
    parameter int FRAME_LINE   = 480,
    parameter int LIVES        = 3,
    parameter int HIT_FRAMES   = 120,
    parameter int CLEAR_FRAMES = 90,
    parameter int OVER_FRAMES  = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic [1:0]  btn1,
    input  logic [1:0]  btn2,
    input  logic        kill,
    input  logic        hit,
    input  logic        cleared,
    input  logic        landed,
    output logic [2:0]  state,
    output logic        run,
    output logic        frame_tick,
    output logic        wave_init,
    output logic        respawn,
    output logic [3:0]  level,
    output logic [1:0]  lives,
    output logic [15:0] score
);

    typedef enum logic [2:0] {
        TITLE = 3'd0,
        PLAY  = 3'd1,
        HIT   = 3'd2,
        CLEAR = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t      cur, nxt;
    logic [7:0]  timer, timer_d;
    logic [3:0]  level_d;
    logic [1:0]  lives_d;
    logic [15:0] score_d;
    logic        wave_d, respawn_d;
    logic        btn_prev, rst_d, any_btn, start, expire;

    // rst_d masks the first cycle after reset so a button held through
    // reset release is seen as already pressed.
    assign any_btn = |{btn1, btn2};
    assign start   = any_btn & ~btn_prev & ~rst_d;
    assign expire  = frame_tick && (timer == 8'd1);
    assign state   = cur;

    function automatic logic [15:0] add10(input logic [15:0] s);
        logic [15:0] r;
        logic        c;
        r = s;
        c = 1'b1;
        if (s[15:4] == 12'h999) return s;
        for (int i = 1; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= TITLE;
            run        <= 1'b0;
            frame_tick <= 1'b0;
            wave_init  <= 1'b0;
            respawn    <= 1'b0;
            level      <= 4'd0;
            lives      <= 2'd0;
            score      <= 16'd0;
            timer      <= 8'd0;
            btn_prev   <= 1'b0;
            rst_d      <= 1'b1;
        end else begin
            cur        <= nxt;
            run        <= (nxt == PLAY);
            frame_tick <= (x == 11'd0) && (y == 11'(FRAME_LINE));
            wave_init  <= wave_d;
            respawn    <= respawn_d;
            level      <= level_d;
            lives      <= lives_d;
            score      <= score_d;
            timer      <= timer_d;
            btn_prev   <= any_btn;
            rst_d      <= 1'b0;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            TITLE: if (start) nxt = PLAY;
            PLAY: begin
                if (landed)       nxt = OVER;
                else if (hit)     nxt = (lives <= 2'd1) ? OVER : HIT;
                else if (cleared) nxt = CLEAR;
            end
            HIT:   if (expire) nxt = PLAY;
            CLEAR: if (expire) nxt = PLAY;
            OVER:  if (start && timer == 8'd0) nxt = TITLE;
            default: nxt = TITLE;
        endcase
    end

    always_comb begin
        level_d   = level;
        lives_d   = lives;
        score_d   = score;
        wave_d    = 1'b0;
        respawn_d = 1'b0;
        timer_d   = (frame_tick && timer != 8'd0) ? timer - 8'd1 : timer;
        if (cur == PLAY && kill) score_d = add10(score);
        case (cur)
            TITLE: begin
                if (start) begin
                    score_d   = 16'd0;
                    lives_d   = 2'(LIVES);
                    level_d   = 4'd1;
                    wave_d    = 1'b1;
                    respawn_d = 1'b1;
                end
            end
            PLAY: begin
                if (landed) begin
                    lives_d = 2'd0;
                    timer_d = 8'(OVER_FRAMES);
                end else if (hit) begin
                    if (lives <= 2'd1) begin
                        lives_d = 2'd0;
                        timer_d = 8'(OVER_FRAMES);
                    end else begin
                        lives_d = lives - 2'd1;
                        timer_d = 8'(HIT_FRAMES);
                    end
                end else if (cleared) begin
                    timer_d = 8'(CLEAR_FRAMES);
                end
            end
            HIT: if (expire) respawn_d = 1'b1;
            CLEAR: begin
                if (expire) begin
                    level_d   = (level == 4'd15) ? 4'd15 : level + 4'd1;
                    wave_d    = 1'b1;
                    respawn_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Frame-synchronous game sequencer for the two-player Space Invaders design. It sits between the debounced buttons, the `vga_sync` pixel counters and the `graphic` datapath. It decides when the playfield runs, pauses, respawns, advances a level or ends. It also owns the lives, level and BCD score registers that `graphic` renders.

## Interface
Parameters:
- `FRAME_LINE`, 480: value of `y` that, together with `x == 0`, defines the once-per-frame tick.
- `LIVES`, 3: lives loaded at game start (1..3).
- `HIT_FRAMES`, 120: length of the post-hit pause, in frames (1..255).
- `CLEAR_FRAMES`, 90: length of the level-clear pause, in frames (1..255).
- `OVER_FRAMES`, 60: frames during which start is ignored after game over (1..255).

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `x`, in, 11: current pixel column from `vga_sync`.
- `y`, in, 11: current pixel row from `vga_sync`.
- `btn1`, in, 2: debounced player-1 buttons (levels).
- `btn2`, in, 2: debounced player-2 buttons (levels).
- `kill`, in, 1: one-cycle pulse from `graphic`; an alien was destroyed.
- `hit`, in, 1: one-cycle pulse; the player ship was hit.
- `cleared`, in, 1: one-cycle pulse; the last alien of the wave was destroyed.
- `landed`, in, 1: one-cycle pulse; the aliens reached the ship row.
- `state`, out, 3: TITLE=0, PLAY=1, HIT=2, CLEAR=3, OVER=4.
- `run`, out, 1: high only in PLAY; enables motion in `graphic`.
- `frame_tick`, out, 1: one-cycle frame pulse.
- `wave_init`, out, 1: one-cycle pulse; `graphic` reloads the alien formation.
- `respawn`, out, 1: one-cycle pulse; `graphic` recentres the ship and clears its shots.
- `level`, out, 4: current level.
- `lives`, out, 2: remaining lives.
- `score`, out, 16: four BCD digits.

## Operation
- `frame_tick`: registered version of (`x == 0` and `y == FRAME_LINE`).
- `start`: rising edge of the OR of all four button bits. It uses a registered previous value and is not pulse-stretched.
- Timer: 8 bits. It is loaded with N on state entry and decrements on each `frame_tick`. On the tick where the timer equals 1, the block transitions (or, in OVER, arms). The exit therefore falls exactly on the Nth tick after entry.

TITLE:
- On `start`, go to PLAY and load `score` = 0, `lives` = LIVES, `level` = 1.
- Pulse `wave_init` and `respawn`.

PLAY:
- Event priority is `landed` > `hit` > `cleared`.
- `landed`: set `lives` = 0 and go to OVER.
- `hit` with `lives` == 1: set `lives` = 0 and go to OVER.
- `hit` with `lives` > 1: decrement `lives` and go to HIT.
- `cleared`: go to CLEAR.

HIT:
- `run` = 0.
- When the timer expires, go to PLAY and pulse `respawn`.

CLEAR:
- `run` = 0.
- When the timer expires, set `level` = min(`level`+1, 15), pulse `wave_init` and `respawn`, and go to PLAY.

OVER:
- `run` = 0.
- `start` is ignored until OVER_FRAMES ticks have elapsed. After that, `start` returns to TITLE.
- `score`, `level` and `lives` hold for display.

Score:
- A `kill` in PLAY adds 10: the tens digit is incremented with BCD carry into the hundreds and thousands digits. The ones digit is always 0.
- The score saturates at 9990.
- A `kill` is counted even when it arrives in the same cycle as `hit`, `cleared` or `landed`.

Ignored events:
- `kill`, `hit`, `cleared` and `landed` are ignored outside PLAY.
- `start` is ignored in PLAY, HIT and CLEAR.

## Timing
- All outputs are registered.
- Reset values: `state` = TITLE, `run` = 0, `frame_tick` = 0, `wave_init` = 0, `respawn` = 0, `level` = 0, `lives` = 0, `score` = 0, timer = 0, previous-button register = 0.
- A button held high through reset release must not produce a start.
- Event-to-effect latency is one cycle. An input event sampled at edge k updates `state`, `lives`, `score` and `run` at edge k+1. The `wave_init`/`respawn` pulses are also driven at edge k+1 and are high for exactly one cycle.
- `frame_tick` is high for the single cycle after the (`x == 0`, `y == FRAME_LINE`) pixel.
- A `reset` asserted mid-operation (any state, timer running) returns everything to its reset values on the next edge. No pulse is emitted.

## Test plan
- Reset, then raise `btn2[1]`: next cycle `state` = 1, `lives` = 3, `level` = 1, `score` = 0x0000, `wave_init` and `respawn` high for one cycle.
- In PLAY, issue 3 `kill` pulses, then `kill` when `score` = 0x0990: `score` = 0x0030, then 0x1000. Starting from 0x9990, one more `kill` leaves 0x9990.
- In PLAY with `lives` = 3, pulse `hit`: `state` = 2, `lives` = 2, `run` = 0. Exactly 120 `frame_tick`s later `state` = 1 and `respawn` pulses once.
- Pulse `hit` and `cleared` in the same cycle with `lives` = 1: `state` = 4, `lives` = 0. Then `start` before 60 frames leaves `state` at 4, and `start` after 60 frames sets `state` = 0.
- Pulse `cleared` at `level` = 15: after 90 frames `level` stays 15 and `wave_init` pulses. Assert `reset` mid-CLEAR: next cycle `state` = 0 and all outputs are 0.
- Pulse `landed` together with `kill` at `lives` = 3: `state` = 4, `lives` = 0, `score` is incremented by 10.
